// File: rtl/exec_acc8.sv
// exec_acc8: single-accumulator execute unit driven by an external
// fetch/decode sequencer. One operation per enable pulse taken in IDLE;
// operands come from a RAM with one cycle of read latency.
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_IDLE    | waiting for enable; instr/address latched on enable
// S_RD_REQ  | operand address on mem_addr, RAM read in flight
// S_RD_WAIT | mem_rdata valid; acc/flags updated at the closing edge
// S_WR      | mem_we pulse with mem_wdata = acc
// S_DONE    | one-cycle completion pulse, then back to IDLE
module exec_acc8 #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [2:0]    instr,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          zero,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_instr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_acc;
  logic          r_carry;
  logic          r_zero;
  logic          r_illegal;

  logic          w_latch;
  logic          w_op_illegal;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;

  assign w_latch      = (r_state == S_IDLE) && enable;
  assign w_op_illegal = (instr > OP_STR);
  assign w_sum        = {1'b0, r_acc} + {1'b0, mem_rdata};
  // top bit of the widened difference is the borrow, i.e. mem_rdata > acc
  assign w_diff       = {1'b0, r_acc} - {1'b0, mem_rdata};

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          case (instr)
            OP_LD, OP_ADD, OP_SUB: w_state_nxt = S_RD_REQ;
            OP_STR:                w_state_nxt = S_WR;
            default:               w_state_nxt = S_DONE;
          endcase
        end
      end
      S_RD_REQ:  w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_DONE;
      S_WR:      w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state; the write strobe is masked by reset so a
  // reset landing in WR cannot let the RAM capture a write at that edge
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    mem_we    = (r_state == S_WR) && !reset;
    mem_wdata = (r_state == S_WR) ? r_acc : '0;
  end

  // operand latch, accumulator/flag update and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr   <= OP_NOP;
      r_addr    <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      if (w_latch) begin
        r_instr <= instr;
        r_addr  <= address;
        if (w_op_illegal) r_illegal <= 1'b1;
      end
      if (r_state == S_RD_WAIT) begin
        case (r_instr)
          OP_LD: begin
            r_acc   <= mem_rdata;
            r_carry <= 1'b0;
            r_zero  <= (mem_rdata == '0);
          end
          OP_ADD: begin
            r_acc   <= w_sum[DW-1:0];
            r_carry <= w_sum[DW];
            r_zero  <= (w_sum[DW-1:0] == '0);
          end
          OP_SUB: begin
            r_acc   <= w_diff[DW-1:0];
            r_carry <= w_diff[DW];
            r_zero  <= (w_diff[DW-1:0] == '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign acc      = r_acc;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign illegal  = r_illegal;

endmodule
